// File: rtl/fp_panel_ctl.sv
// Front panel command controller: turns debounced switch presses into panel
// actions, runs examine/deposit memory handshakes and drives the LED words.
module fp_panel_ctl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  fnsw,
  input  logic [4:0]  rotsw,
  input  logic [11:0] swreg,
  input  logic        cpu_running,
  input  logic [11:0] ac_in,
  input  logic [11:0] mq_in,
  input  logic [11:0] flags_in,
  input  logic [3:0]  post_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [11:0] mem_rdata,
  output logic        halt_req,
  output logic        cont_req,
  output logic        boot_req,
  output logic        clear_req,
  output logic        mem_timeout,
  output logic        busy,
  output logic [11:0] data_leds,
  output logic [11:0] addr_leds,
  output logic [2:0]  ema_leds
);

  localparam int unsigned FNSW_BOOT  = 0;
  localparam int unsigned FNSW_CLEAR = 1;
  localparam int unsigned FNSW_CONT  = 2;
  localparam int unsigned FNSW_DEP   = 3;
  localparam int unsigned FNSW_EXAM  = 4;
  localparam int unsigned FNSW_HALT  = 5;
  localparam int unsigned FNSW_LA    = 6;
  localparam int unsigned FNSW_LOCK  = 7;
  localparam int unsigned FNSW_LXA   = 8;

  localparam int unsigned ROTSW_AC    = 0;
  localparam int unsigned ROTSW_FLAGS = 1;
  localparam int unsigned ROTSW_MD    = 2;
  localparam int unsigned ROTSW_MQ    = 3;
  localparam int unsigned ROTSW_POST  = 4;

  localparam logic [15:0] TIMEOUT_VAL = 16'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ACKED} state_e;
  typedef enum logic [3:0] {
    A_NONE, A_HALT, A_CLEAR, A_BOOT, A_CONT, A_DEP, A_EXAM, A_LXA, A_LA
  } action_e;

  state_e      state, state_nx;
  action_e     win, pend;
  logic [15:0] timer, timer_nx;
  logic [8:0]  fprev, keep;
  logic [11:0] pend_data, cpa, md, wdata, rdata_q, display;
  logic [2:0]  ema;
  logic        wr_q, done, timeout_nx;

  // Press detection, filtering and priority. The winner is registered into
  // pend and acts one clock later, so a pending memory action also blocks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    keep = fnsw & ~fprev;
    win  = A_NONE;
    if (fnsw[FNSW_LOCK] || busy || pend == A_EXAM || pend == A_DEP) keep = '0;
    if (cpu_running) keep = keep & (9'd1 << FNSW_HALT);
    if      (keep[FNSW_HALT])  win = A_HALT;
    else if (keep[FNSW_CLEAR]) win = A_CLEAR;
    else if (keep[FNSW_BOOT])  win = A_BOOT;
    else if (keep[FNSW_CONT])  win = A_CONT;
    else if (keep[FNSW_DEP])   win = A_DEP;
    else if (keep[FNSW_EXAM])  win = A_EXAM;
    else if (keep[FNSW_LXA])   win = A_LXA;
    else if (keep[FNSW_LA])    win = A_LA;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before the edge.
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // An ack is registered into S_ACKED and retired on the following clock.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    done       = 1'b0;
    timeout_nx = 1'b0;
    busy       = (state != S_IDLE);
    mem_req    = busy;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (pend == A_EXAM) begin
          state_nx = S_READ;
          timer_nx = 16'd1;
        end else if (pend == A_DEP) begin
          state_nx = S_WRITE;
          timer_nx = 16'd1;
        end
      end
      S_READ, S_WRITE: begin
        if (mem_ack) begin
          state_nx = S_ACKED;
        end else if (timer == TIMEOUT_VAL) begin
          state_nx   = S_IDLE;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      S_ACKED: begin
        state_nx = S_IDLE;
        done     = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem_wr    = busy & wr_q;
  assign mem_addr  = {ema, cpa};
  assign mem_wdata = wdata;

  always_comb begin
    display = md;
    if      (rotsw[ROTSW_AC])    display = ac_in;
    else if (rotsw[ROTSW_MQ])    display = mq_in;
    else if (rotsw[ROTSW_FLAGS]) display = flags_in;
    else if (rotsw[ROTSW_MD])    display = md;
    else if (rotsw[ROTSW_POST])  display = {8'b0, post_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fprev       <= '0;
      pend        <= A_NONE;
      pend_data   <= '0;
      cpa         <= '0;
      ema         <= '0;
      md          <= '0;
      wdata       <= '0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      halt_req    <= 1'b0;
      cont_req    <= 1'b0;
      boot_req    <= 1'b0;
      clear_req   <= 1'b0;
      mem_timeout <= 1'b0;
      data_leds   <= '0;
      addr_leds   <= '0;
      ema_leds    <= '0;
    end else begin
      fprev       <= fnsw;
      pend        <= win;
      if (win != A_NONE) pend_data <= swreg;
      halt_req    <= (pend == A_HALT);
      clear_req   <= (pend == A_CLEAR);
      boot_req    <= (pend == A_BOOT);
      cont_req    <= (pend == A_CONT);
      mem_timeout <= timeout_nx;
      // swreg bit 0 is the MSB, so panel bits 9..11 are vector bits 2..0.
      if (pend == A_LA)  cpa <= pend_data;
      if (pend == A_LXA) ema <= pend_data[2:0];
      if (state == S_IDLE && pend == A_DEP) begin
        wdata <= pend_data;
        wr_q  <= 1'b1;
      end
      if (state == S_IDLE && pend == A_EXAM) wr_q <= 1'b0;
      if ((state == S_READ || state == S_WRITE) && mem_ack) rdata_q <= mem_rdata;
      if (done) begin
        md  <= wr_q ? wdata : rdata_q;
        cpa <= cpa + 12'd1;
      end
      data_leds <= display;
      addr_leds <= cpa;
      ema_leds  <= ema;
    end
  end

endmodule
